// File: rtl/sim_ram_pkg.sv
// sim_ram_pkg: shared constants and helpers for the sim_ram family.
// Read-during-write mode codes, index width and byte-lane count.
package sim_ram_pkg;

  localparam int NO_CHANGE   = 0;
  localparam int WRITE_FIRST = 1;
  localparam int READ_FIRST  = 2;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Never returns 0 so a one-word array still gets a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int lanes(input int dw, input int bw);
    return (dw + bw - 1) / bw;
  endfunction

endpackage

// File: rtl/sim_ram_rd_pipe.sv
// sim_ram_rd_pipe: read-data delay line for one RAM port.
// The last stage doubles as the output-hold register.
module sim_ram_rd_pipe
  import sim_ram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_vld,
  input  logic [DW-1:0] rd_dat,
  output logic          rvld,
  output logic [DW-1:0] dout
);

  logic          lst_vld;
  logic [DW-1:0] lst_dat;

  generate
    if (RD_LAT > RD_LAT_MIN) begin : g_dly
      localparam int N = RD_LAT - 1;

      logic [N-1:0]         vld_q;
      logic [N-1:0][DW-1:0] dat_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q[0] <= rd_vld;
          dat_q[0] <= rd_dat;
          for (int i = 1; i < N; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign lst_vld = vld_q[N-1];
      assign lst_dat = dat_q[N-1];
    end else begin : g_nodly
      assign lst_vld = rd_vld;
      assign lst_dat = rd_dat;
    end
  endgenerate

  // dout only moves when a read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld <= 1'b0;
      dout <= '0;
    end else begin
      rvld <= lst_vld;
      if (lst_vld) dout <= lst_dat;
    end
  end

endmodule

// File: rtl/sim_ram_dp.sv
// sim_ram_dp: true-dual-port SRAM simulation model, ports A and B.
// Build option SIM_RAM_X2ZERO_EN: X/Z bits on read data forced to 0.
module sim_ram_dp
  import sim_ram_pkg::*;
#(
  parameter int    DP        = 512,
  parameter int    DW        = 32,
  parameter int    BW        = 8,
  parameter int    AW        = 32,
  parameter int    RD_LAT    = 1,
  parameter int    WR_MODE   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_en,
  input  logic                     a_we,
  input  logic [lanes(DW,BW)-1:0]  a_wem,
  input  logic [AW-1:0]            a_addr,
  input  logic [DW-1:0]            a_din,
  output logic [DW-1:0]            a_dout,
  output logic                     a_rvld,
  input  logic                     b_en,
  input  logic                     b_we,
  input  logic [lanes(DW,BW)-1:0]  b_wem,
  input  logic [AW-1:0]            b_addr,
  input  logic [DW-1:0]            b_din,
  output logic [DW-1:0]            b_dout,
  output logic                     b_rvld,
  output logic                     col_err,
  output logic                     oor_err
);

  localparam int       MW   = lanes(DW, BW);
  localparam int       IW   = clog2(DP);
  localparam bit       RD_W = (WR_MODE != NO_CHANGE);
  localparam bit       WF   = (WR_MODE == WRITE_FIRST);
  localparam [AW:0]    LIM  = (AW+1)'(DP);

  logic [DW-1:0] mem [DP];

  logic [IW-1:0] a_idx, b_idx;
  logic          a_oor, b_oor;
  logic          a_wr, b_wr;
  logic          a_rd, b_rd;
  logic [DW-1:0] a_bm, b_bm;
  logic [DW-1:0] a_old, b_old;
  logic [DW-1:0] a_new, b_new;
  logic [DW-1:0] ab_new;
  logic [DW-1:0] a_rdat, b_rdat;
  logic [DW-1:0] a_raw, b_raw;
  logic          col_d, oor_d;

  assign a_idx = a_addr[IW-1:0];
  assign b_idx = b_addr[IW-1:0];
  assign a_oor = ({1'b0, a_addr} >= LIM);
  assign b_oor = ({1'b0, b_addr} >= LIM);

  // Expand each lane enable over its bits; top lane may be short.
  generate
    for (genvar l = 0; l < MW; l++) begin : g_lane
      localparam int LO = l * BW;
      localparam int HI = ((LO + BW) > DW) ? DW - 1 : LO + BW - 1;
      assign a_bm[HI:LO] = {(HI-LO+1){a_wem[l]}};
      assign b_bm[HI:LO] = {(HI-LO+1){b_wem[l]}};
    end
  endgenerate

  assign a_wr = a_en & a_we & ~a_oor;
  assign b_wr = b_en & b_we & ~b_oor;
  assign a_rd = a_en & (~a_we | RD_W);
  assign b_rd = b_en & (~b_we | RD_W);

  assign a_old = a_oor ? '0 : mem[a_idx];
  assign b_old = b_oor ? '0 : mem[b_idx];
  assign a_new = (a_old & ~a_bm) | (a_din & a_bm);
  assign b_new = (b_old & ~b_bm) | (b_din & b_bm);

  // A layered over B for a same-index double write.
  assign ab_new = (b_new & ~a_bm) | (a_din & a_bm);

  always_comb begin
    a_rdat = a_old;
    b_rdat = b_old;
    if (WF && a_we && !a_oor) a_rdat = a_new;
    if (WF && b_we && !b_oor) b_rdat = b_new;
  end

  always_ff @(posedge clk) begin
    if (b_wr) mem[b_idx] <= b_new;
    if (a_wr) mem[a_idx] <= (b_wr && b_idx == a_idx) ? ab_new : a_new;
  end

  assign col_d = a_en & b_en & ~a_oor & ~b_oor &
                 (a_idx == b_idx) & (a_we | b_we);
  assign oor_d = (a_en & a_oor) | (b_en & b_oor);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_err <= 1'b0;
      oor_err <= 1'b0;
    end else begin
      col_err <= col_d;
      oor_err <= oor_d;
    end
  end

  sim_ram_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_a (
    .clk    (clk),
    .rst    (rst),
    .rd_vld (a_rd),
    .rd_dat (a_rdat),
    .rvld   (a_rvld),
    .dout   (a_raw)
  );

  sim_ram_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_b (
    .clk    (clk),
    .rst    (rst),
    .rd_vld (b_rd),
    .rd_dat (b_rdat),
    .rvld   (b_rvld),
    .dout   (b_raw)
  );

`ifdef SIM_RAM_X2ZERO_EN
`ifndef SYNTHESIS
  always_comb begin
    a_dout = '0;
    b_dout = '0;
    for (int i = 0; i < DW; i++) begin
      a_dout[i] = (a_raw[i] === 1'b1);
      b_dout[i] = (b_raw[i] === 1'b1);
    end
  end
`else
  assign a_dout = a_raw;
  assign b_dout = b_raw;
`endif
`else
  assign a_dout = a_raw;
  assign b_dout = b_raw;
`endif

endmodule
